// File: rtl/check.sv
// Result checker: pops expected records and captured DUT outputs in lockstep,
// compares under a programmable bitmask, logs each mismatch as a 3-word
// record over an Avalon-MM write master and keeps saturating pass/fail totals.
module check #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned STF_WIDTH  = 24,
  parameter int unsigned CHF_WIDTH  = STF_WIDTH + ADDR_WIDTH,
  parameter int unsigned SCC_WIDTH  = 5,
  parameter int unsigned SCD_WIDTH  = 24,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] LOG_BASE  = 20'h80000,
  parameter logic [ADDR_WIDTH-1:0] LOG_LIMIT = 20'hFFFFD
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  done,
  input  logic [CHF_WIDTH-1:0]  cfifo_data,
  output logic                  cfifo_rdreq,
  input  logic                  cfifo_rdempty,
  input  logic [STF_WIDTH-1:0]  rfifo_data,
  output logic                  rfifo_rdreq,
  input  logic                  rfifo_rdempty,
  input  logic [SCC_WIDTH-1:0]  sc_cmd,
  input  logic [SCD_WIDTH-1:0]  sc_data,
  output logic                  sc_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  log_overflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [SCC_WIDTH-1:0] CMD_MASK = SCC_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_COMPARE,
    S_WR0,
    S_WR1,
    S_WR2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [STF_WIDTH-1:0]  r_mask;
  logic [STF_WIDTH-1:0]  r_expected;
  logic [STF_WIDTH-1:0]  r_actual;
  logic [ADDR_WIDTH-1:0] r_vec_addr;
  // One extra bit so the pointer cannot wrap past the top of memory and
  // re-pass the limit check after the last legal record.
  logic [PW-1:0]         r_log_ptr;
  logic [CNT_WIDTH-1:0]  r_pass_count;
  logic [CNT_WIDTH-1:0]  r_fail_count;
  logic                  r_log_overflow;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_writedata;

  logic                  w_start;
  logic                  w_fail;
  logic                  w_log_ok;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_ptr0;
  logic [ADDR_WIDTH-1:0] w_ptr1;
  logic [ADDR_WIDTH-1:0] w_ptr2;

  // Pop/compare qualifiers and record addresses.
  always_comb begin
    w_start  = reset_n & (r_state == S_IDLE) & enable & ~cfifo_rdempty & ~rfifo_rdempty;
    w_fail   = |((r_actual ^ r_expected) & r_mask);
    w_log_ok = (r_log_ptr <= {1'b0, LOG_LIMIT});
    w_accept = ~mem_waitrequest;
    w_ptr0   = r_log_ptr[ADDR_WIDTH-1:0];
    w_ptr1   = w_ptr0 + ADDR_WIDTH'(1);
    w_ptr2   = w_ptr0 + ADDR_WIDTH'(2);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_FETCH;
      S_FETCH:   w_next = S_COMPARE;
      S_COMPARE: w_next = (w_fail && w_log_ok) ? S_WR0 : S_IDLE;
      S_WR0:     if (w_accept) w_next = S_WR1;
      S_WR1:     if (w_accept) w_next = S_WR2;
      S_WR2:     if (w_accept) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: mask load, operand capture, counters and failure-record writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mask          <= '1;
      r_expected      <= '0;
      r_actual        <= '0;
      r_vec_addr      <= '0;
      r_log_ptr       <= {1'b0, LOG_BASE};
      r_pass_count    <= '0;
      r_fail_count    <= '0;
      r_log_overflow  <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      if (sc_cmd == CMD_MASK) r_mask <= sc_data[STF_WIDTH-1:0];
      case (r_state)
        S_FETCH: begin
          r_expected <= cfifo_data[CHF_WIDTH-1 -: STF_WIDTH];
          r_vec_addr <= cfifo_data[ADDR_WIDTH-1:0];
          r_actual   <= rfifo_data;
        end
        S_COMPARE: begin
          if (!w_fail) begin
            if (r_pass_count != '1) r_pass_count <= r_pass_count + CNT_WIDTH'(1);
          end else begin
            if (r_fail_count != '1) r_fail_count <= r_fail_count + CNT_WIDTH'(1);
            if (w_log_ok) begin
              r_mem_write     <= 1'b1;
              r_mem_address   <= w_ptr0;
              r_mem_writedata <= r_vec_addr[15:0];
            end else begin
              r_log_overflow  <= 1'b1;
            end
          end
        end
        S_WR0: if (w_accept) begin
          r_mem_address   <= w_ptr1;
          r_mem_writedata <= {r_vec_addr[19:16], 4'h0, r_actual[23:16]};
        end
        S_WR1: if (w_accept) begin
          r_mem_address   <= w_ptr2;
          r_mem_writedata <= r_actual[15:0];
        end
        S_WR2: if (w_accept) begin
          r_mem_write <= 1'b0;
          r_log_ptr   <= r_log_ptr + PW'(3);
        end
        default: ;
      endcase
    end
  end

  assign cfifo_rdreq    = w_start;
  assign rfifo_rdreq    = w_start;
  assign sc_ready       = (r_state == S_IDLE);
  assign done           = (r_state == S_IDLE) & cfifo_rdempty;
  assign mem_address    = r_mem_address;
  assign mem_byteenable = '1;
  assign mem_write      = r_mem_write;
  assign mem_writedata  = r_mem_writedata;
  assign pass_count     = r_pass_count;
  assign fail_count     = r_fail_count;
  assign log_overflow   = r_log_overflow;

endmodule

// File: tb/tb_check.sv
// Bench for the result checker: emulated FIFOs and memory slave, directed
// scenarios plus randomized batches against a behavioural scoreboard.
module tb_check;

  localparam logic [19:0] BASE  = 20'h80000;
  localparam logic [19:0] LIMIT = 20'h80003;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        done;
  logic [43:0] cfifo_data;
  logic        cfifo_rdreq;
  logic        cfifo_rdempty;
  logic [23:0] rfifo_data;
  logic        rfifo_rdreq;
  logic        rfifo_rdempty;
  logic [4:0]  sc_cmd;
  logic [23:0] sc_data;
  logic        sc_ready;
  logic [19:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic        mem_waitrequest;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic        log_overflow;

  always #5 clock = ~clock;

  check #(.LOG_LIMIT(LIMIT)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .done(done),
    .cfifo_data(cfifo_data), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
    .rfifo_data(rfifo_data), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .pass_count(pass_count), .fail_count(fail_count), .log_overflow(log_overflow)
  );

  // FIFO emulation: data appears the cycle after rdreq.
  logic [43:0] c_mem [0:1023];
  logic [23:0] r_mem [0:1023];
  int c_wr = 0, c_rd = 0, r_wr = 0, r_rd = 0;
  assign cfifo_rdempty = (c_wr == c_rd);
  assign rfifo_rdempty = (r_wr == r_rd);
  always @(posedge clock) begin
    if (cfifo_rdreq) begin cfifo_data <= c_mem[c_rd]; c_rd <= c_rd + 1; end
    if (rfifo_rdreq) begin rfifo_data <= r_mem[r_rd]; r_rd <= r_rd + 1; end
  end

  // Memory slave: log every accepted write.
  logic [19:0] w_addr [0:1023];
  logic [15:0] w_data [0:1023];
  int wn = 0;
  always @(posedge clock) begin
    if (mem_write && !mem_waitrequest && wn < 1023) begin
      w_addr[wn] <= mem_address;
      w_data[wn] <= mem_writedata;
      wn <= wn + 1;
    end
  end

  // Background driver for waitrequest/enable (directed or random).
  bit   rand_wait = 0, rand_en = 0;
  logic force_wait = 1'b0, en_ctl = 1'b1;
  initial begin
    mem_waitrequest = 1'b0;
    enable = 1'b1;
    forever begin
      @(negedge clock);
      #1;
      mem_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : force_wait;
      enable          = rand_en ? ($urandom_range(0, 3) != 0) : en_ctl;
    end
  end

  // Scoreboard.
  int total = 0, bad = 0;
  int m_pass, m_fail, m_ptr, wbase;
  bit m_ovf;
  int e_addr[$];
  int e_data[$];
  logic [23:0] cur_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pass = 0; m_fail = 0; m_ovf = 0; m_ptr = BASE;
    e_addr.delete(); e_data.delete();
    cur_mask = '1;
  endtask

  task automatic model_vec(input logic [23:0] exp_v, input logic [23:0] act,
                           input logic [19:0] va, input logic [23:0] mask);
    if (((exp_v ^ act) & mask) == 24'h0) begin
      if (m_pass < 65535) m_pass++;
    end else begin
      if (m_fail < 65535) m_fail++;
      if (m_ptr <= int'(LIMIT)) begin
        e_addr.push_back(m_ptr);     e_data.push_back(int'(va[15:0]));
        e_addr.push_back(m_ptr + 1); e_data.push_back(int'({va[19:16], 4'h0, act[23:16]}));
        e_addr.push_back(m_ptr + 2); e_data.push_back(int'(act[15:0]));
        m_ptr += 3;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic push(input logic [23:0] exp_v, input logic [23:0] act, input logic [19:0] va);
    c_mem[c_wr] = {exp_v, va}; c_wr++;
    r_mem[r_wr] = act;         r_wr++;
  endtask

  task automatic vec(input logic [23:0] exp_v, input logic [23:0] act, input logic [19:0] va);
    push(exp_v, act, va);
    model_vec(exp_v, act, va, cur_mask);
  endtask

  task automatic set_mask(input logic [23:0] m);
    @(negedge clock); sc_cmd = 5'b00001; sc_data = m;
    @(negedge clock); sc_cmd = 5'b00000;
    cur_mask = m;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (!(done === 1'b1 && r_wr == r_rd && c_wr == c_rd) && n < 3000) begin
      @(negedge clock); n++;
    end
    chk("idle_reached", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_wr1();
    int n = 0;
    while (!(mem_write === 1'b1 && mem_address === BASE + 20'd1) && n < 50) begin
      @(negedge clock); n++;
    end
    chk("wr1_reached", {12'b0, mem_address}, {12'b0, BASE + 20'd1});
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pass"}, {16'b0, pass_count}, m_pass);
    chk({tag, "_fail"}, {16'b0, fail_count}, m_fail);
    chk({tag, "_ovf"}, {31'b0, log_overflow}, {31'b0, m_ovf});
    chk({tag, "_wrcnt"}, wn - wbase, e_addr.size());
    for (int i = 0; i < e_addr.size(); i++) begin
      chk({tag, "_wraddr"}, {12'b0, w_addr[wbase + i]}, e_addr[i]);
      chk({tag, "_wrdata"}, {16'b0, w_data[wbase + i]}, e_data[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clock); reset_n = 1'b0; sc_cmd = '0;
    @(negedge clock);
    @(negedge clock); reset_n = 1'b1;
    model_reset();
    wbase = wn;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0, r0;
    logic [23:0] a0, e0, fl, m;
    logic [19:0] hold_a;
    logic [15:0] hold_d;

    reset_n = 1'b0; sc_cmd = '0; sc_data = '0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_mem_write", {31'b0, mem_write}, 0);
    chk("rst_mem_addr", {12'b0, mem_address}, 0);
    chk("rst_mem_data", {16'b0, mem_writedata}, 0);
    chk("rst_be", {30'b0, mem_byteenable}, 3);
    chk("rst_pass", {16'b0, pass_count}, 0);
    chk("rst_fail", {16'b0, fail_count}, 0);
    chk("rst_ovf", {31'b0, log_overflow}, 0);
    chk("rst_sc_ready", {31'b0, sc_ready}, 1);
    chk("rst_done", {31'b0, done}, 1);
    chk("rst_crd", {31'b0, cfifo_rdreq}, 0);
    chk("rst_rrd", {31'b0, rfifo_rdreq}, 0);
    reset_n = 1'b1;
    wbase = wn;

    // Pass path with reset mask.
    c0 = c_rd; r0 = r_rd;
    vec(24'hA5A5A5, 24'hA5A5A5, 20'h00010);
    wait_idle();
    check_state("passpath");
    chk("pass_cpops", c_rd - c0, 1);
    chk("pass_rpops", r_rd - r0, 1);

    // Masked compare: upper-byte difference ignored, low-byte difference logged.
    set_mask(24'h0000FF);
    vec(24'h123456, 24'hFF3456, 20'h00010);
    wait_idle();
    vec(24'h123456, 24'h123457, 20'h00010);
    wait_idle();
    check_state("masked");

    // Waitrequest held 5 cycles during WR1, then pointer continues at BASE+3.
    do_reset();
    vec(24'h000000, 24'h000001, 20'hABCDE);
    wait_wr1();
    force_wait = 1'b1;
    hold_a = mem_address; hold_d = mem_writedata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_write", {31'b0, mem_write}, 1);
      chk("stall_addr", {12'b0, mem_address}, {12'b0, hold_a});
      chk("stall_data", {16'b0, mem_writedata}, {16'b0, hold_d});
    end
    force_wait = 1'b0;
    wait_idle();
    check_state("wait");
    vec(24'h000000, 24'h000002, 20'h00001);
    wait_idle();
    check_state("wait_next");

    // Log overflow: third failure has no room.
    do_reset();
    vec(24'h111111, 24'h111110, 20'h00003);
    vec(24'h222222, 24'h022222, 20'h00004);
    vec(24'h333333, 24'h333033, 20'h00005);
    wait_idle();
    check_state("ovf");

    // Mask load during COMPARE affects only later vectors.
    do_reset();
    vec(24'h000000, 24'h000001, 20'h00055);
    @(negedge clock);
    @(negedge clock);
    sc_cmd = 5'b00001; sc_data = 24'h000000;
    @(negedge clock);
    sc_cmd = 5'b00000;
    cur_mask = 24'h000000;
    wait_idle();
    vec(24'h000000, 24'h000001, 20'h00055);
    wait_idle();
    check_state("mask_cmp");

    // Flow control: one FIFO empty, then enable low.
    do_reset();
    c_mem[c_wr] = {24'h00F00F, 20'h00001}; c_wr++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("fc_crd", {31'b0, cfifo_rdreq}, 0);
      chk("fc_rrd", {31'b0, rfifo_rdreq}, 0);
      chk("fc_ready", {31'b0, sc_ready}, 1);
      chk("fc_done", {31'b0, done}, 0);
    end
    en_ctl = 1'b0;
    r_mem[r_wr] = 24'h00F00E; r_wr++;
    model_vec(24'h00F00F, 24'h00F00E, 20'h00001, cur_mask);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("en_low_crd", {31'b0, cfifo_rdreq}, 0);
    end
    en_ctl = 1'b1;
    wait_idle();
    check_state("flow");
    vec(24'h0000AA, 24'h0000AB, 20'h00002);
    @(negedge clock);
    en_ctl = 1'b0;
    wait_idle();
    en_ctl = 1'b1;
    check_state("en_mid_record");

    // Reset asserted mid-WR1 drops the write immediately.
    do_reset();
    vec(24'h000000, 24'h000001, 20'h00007);
    wait_wr1();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_write", {31'b0, mem_write}, 0);
    chk("arst_fail", {16'b0, fail_count}, 0);
    chk("arst_addr", {12'b0, mem_address}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    wbase = wn;
    @(negedge clock);
    check_state("arst");

    // Randomized batches with random stalls and enable gaps.
    for (int b = 0; b < 4; b++) begin
      do_reset();
      m = $urandom;
      if (b == 0) m = '1;
      set_mask(m);
      rand_wait = 1; rand_en = 1;
      for (int k = 0; k < 10; k++) begin
        e0 = $urandom;
        case ($urandom_range(0, 2))
          0:       fl = 24'h0;
          1:       fl = 24'h1 << $urandom_range(0, 23);
          default: fl = $urandom;
        endcase
        a0 = e0 ^ fl;
        vec(e0, a0, 20'($urandom));
      end
      wait_idle();
      rand_wait = 0; rand_en = 0;
      check_state("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
